// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: shares the register-file write port between WB (A) and the long-latency unit (B).
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_wb_w/i_wb_dst/i_wb_data        writeback request (A)
//   i_lu_valid/o_lu_ready/i_lu_*     long-latency result handshake into a one-entry buffer (B)
//   i_iss_set/i_iss_dst              mark a destination pending when a long-latency op issues
//   o_busy                           pending-write bit per register
//   o_wb_stall                       one-cycle hold of WB when B has starved
//   o_rf_w/o_rf_dst/o_rf_data        registered register-file write port
module rf_wr_arbiter #(
  parameter int WIDTH        = 32,
  parameter int RF_DEPTH     = 32,
  parameter int RF_ADD_SIZE  = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_wb_w,
  input  logic [RF_ADD_SIZE-1:0] i_wb_dst,
  input  logic [WIDTH-1:0]       i_wb_data,
  input  logic                   i_lu_valid,
  output logic                   o_lu_ready,
  input  logic [RF_ADD_SIZE-1:0] i_lu_dst,
  input  logic [WIDTH-1:0]       i_lu_data,
  input  logic                   i_iss_set,
  input  logic [RF_ADD_SIZE-1:0] i_iss_dst,
  output logic [RF_DEPTH-1:0]    o_busy,
  output logic                   o_wb_stall,
  output logic                   o_rf_w,
  output logic [RF_ADD_SIZE-1:0] o_rf_dst,
  output logic [WIDTH-1:0]       o_rf_data
);
  typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;
  state_t                 r_state;
  logic                   r_buf_valid;
  logic [RF_ADD_SIZE-1:0] r_buf_dst;
  logic [WIDTH-1:0]       r_buf_data;
  logic [3:0]             r_cnt;
  logic [RF_DEPTH-1:0]    r_busy;
  logic                   w_grant_a;
  logic                   w_grant_b;
  logic                   w_capture;
  logic [RF_DEPTH-1:0]    w_busy_nxt;
  assign w_grant_a  = (r_state != FORCE) & i_wb_w & (i_wb_dst != '0);
  assign w_grant_b  = ~w_grant_a & r_buf_valid;
  // Results for x0 complete the handshake but are never buffered.
  assign w_capture  = i_lu_valid & ~r_buf_valid & (i_lu_dst != '0);
  assign o_lu_ready = ~r_buf_valid;
  assign o_busy     = r_busy;
  // Clear on drain first so a same-cycle issue to that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_grant_b) w_busy_nxt[r_buf_dst] = 1'b0;
    if (i_iss_set) w_busy_nxt[i_iss_dst] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_buf_valid <= 1'b0;
      r_buf_dst   <= '0;
      r_buf_data  <= '0;
      r_cnt       <= '0;
      r_busy      <= '0;
      o_wb_stall  <= 1'b0;
      o_rf_w      <= 1'b0;
      o_rf_dst    <= '0;
      o_rf_data   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      o_rf_w <= w_grant_a | w_grant_b;
      if (w_grant_a) begin
        o_rf_dst  <= i_wb_dst;
        o_rf_data <= i_wb_data;
      end else if (w_grant_b) begin
        o_rf_dst  <= r_buf_dst;
        o_rf_data <= r_buf_data;
      end
      if (w_capture) begin
        r_buf_valid <= 1'b1;
        r_buf_dst   <= i_lu_dst;
        r_buf_data  <= i_lu_data;
      end else if (w_grant_b) begin
        r_buf_valid <= 1'b0;
      end
      case (r_state)
        IDLE: if (w_capture) r_state <= WAIT;
        WAIT: begin
          if (w_grant_b) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_grant_a) begin
            r_cnt <= r_cnt + 4'd1;
            // The FORCE transition caps cnt at STARVE_LIMIT, so it cannot wrap.
            if (r_cnt == 4'(STARVE_LIMIT - 1)) begin
              r_state    <= FORCE;
              o_wb_stall <= 1'b1;
            end
          end
        end
        FORCE: begin
          r_state    <= IDLE;
          o_wb_stall <= 1'b0;
          r_cnt      <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb_rf_wr_arbiter: directed and randomized checks of rf_wr_arbiter against a slot/loss-count model.
module tb_rf_wr_arbiter;
  localparam int W = 32, D = 32, A = 5, LIM = 4;
  logic clk = 0, rst = 1;
  logic wb_w = 0, lu_valid = 0, iss_set = 0;
  logic [A-1:0] wb_dst = 0, lu_dst = 0, iss_dst = 0;
  logic [W-1:0] wb_data = 0, lu_data = 0;
  logic o_lu_ready, o_wb_stall, o_rf_w;
  logic [D-1:0] o_busy;
  logic [A-1:0] o_rf_dst;
  logic [W-1:0] o_rf_data;
  int n_checks = 0, n_err = 0, cyc = 0;
  // model: one pending LU slot, count of A wins it has suffered, and a pending forced drain
  bit m_has, m_stall, m_rf_w;
  int m_lost;
  logic [A-1:0] m_dst, m_rf_dst;
  logic [W-1:0] m_data, m_rf_data;
  logic [D-1:0] m_busy;

  rf_wr_arbiter #(.WIDTH(W), .RF_DEPTH(D), .RF_ADD_SIZE(A), .STARVE_LIMIT(LIM)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_w(wb_w), .i_wb_dst(wb_dst), .i_wb_data(wb_data),
    .i_lu_valid(lu_valid), .o_lu_ready(o_lu_ready), .i_lu_dst(lu_dst), .i_lu_data(lu_data),
    .i_iss_set(iss_set), .i_iss_dst(iss_dst), .o_busy(o_busy), .o_wb_stall(o_wb_stall),
    .o_rf_w(o_rf_w), .o_rf_dst(o_rf_dst), .o_rf_data(o_rf_data));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_has = 0; m_stall = 0; m_rf_w = 0; m_lost = 0;
    m_dst = 0; m_data = 0; m_rf_dst = 0; m_rf_data = 0; m_busy = 0;
  endtask

  task automatic model_update();
    bit old_has;
    bit wb_ok;
    old_has = m_has;
    wb_ok = wb_w && wb_dst != 0;
    m_rf_w = 0;
    if (m_stall) begin
      m_rf_w = 1; m_rf_dst = m_dst; m_rf_data = m_data; m_busy[m_dst] = 0;
      m_has = 0; m_lost = 0; m_stall = 0;
    end else if (wb_ok) begin
      m_rf_w = 1; m_rf_dst = wb_dst; m_rf_data = wb_data;
      if (m_has) begin
        m_lost++;
        if (m_lost == LIM) m_stall = 1;
      end
    end else if (m_has) begin
      m_rf_w = 1; m_rf_dst = m_dst; m_rf_data = m_data; m_busy[m_dst] = 0;
      m_has = 0; m_lost = 0;
    end
    if (lu_valid && !old_has && lu_dst != 0) begin
      m_has = 1; m_dst = lu_dst; m_data = lu_data;
    end
    if (iss_set) m_busy[iss_dst] = 1;
    m_busy[0] = 0;
  endtask

  task automatic check_all(input string t);
    chk({t, ".rf_w"}, o_rf_w, m_rf_w);
    chk({t, ".rf_dst"}, o_rf_dst, m_rf_dst);
    chk({t, ".rf_data"}, o_rf_data, m_rf_data);
    chk({t, ".stall"}, o_wb_stall, m_stall);
    chk({t, ".ready"}, o_lu_ready, !m_has);
    chk({t, ".busy"}, o_busy, m_busy);
  endtask

  task automatic step(input string t);
    model_update();
    @(posedge clk);
    #1;
    cyc++;
    check_all(t);
  endtask

  task automatic idle_inputs();
    wb_w = 0; lu_valid = 0; iss_set = 0;
    wb_dst = 0; lu_dst = 0; iss_dst = 0; wb_data = 0; lu_data = 0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("rst0");
    @(posedge clk);
    #1;
    rst = 0;
    // WB only
    wb_w = 1; wb_dst = 5; wb_data = 32'hDEADBEEF;
    step("wb");
    chk("wb_w", o_rf_w, 1); chk("wb_dst", o_rf_dst, 5); chk("wb_data", o_rf_data, 32'hDEADBEEF);
    wb_w = 0;
    step("wb_idle");
    chk("wb_off", o_rf_w, 0); chk("wb_hold", o_rf_dst, 5);
    // LU idle path
    iss_set = 1; iss_dst = 7;
    step("iss");
    iss_set = 0;
    chk("busy7_set", o_busy[7], 1);
    lu_valid = 1; lu_dst = 7; lu_data = 32'h1234;
    step("lu_acc");
    lu_valid = 0;
    chk("lu_rdy_drop", o_lu_ready, 0); chk("lu_no_same_wr", o_rf_w, 0);
    step("lu_wr");
    chk("lu_w", o_rf_w, 1); chk("lu_dst", o_rf_dst, 7); chk("lu_data", o_rf_data, 32'h1234);
    chk("busy7_clr", o_busy[7], 0); chk("lu_rdy_back", o_lu_ready, 1);
    // contention: LU dst 3 buffered behind WB 1, 2
    lu_valid = 1; lu_dst = 3; lu_data = 32'h33;
    step("ct_acc");
    lu_valid = 0;
    wb_w = 1; wb_dst = 1; wb_data = 32'h11;
    step("ct_a1");
    chk("ct_dst1", o_rf_dst, 1);
    wb_dst = 2; wb_data = 32'h22;
    step("ct_a2");
    chk("ct_dst2", o_rf_dst, 2); chk("ct_nostall", o_wb_stall, 0);
    wb_w = 0;
    step("ct_b");
    chk("ct_dst3", o_rf_dst, 3); chk("ct_w3", o_rf_w, 1); chk("ct_stall", o_wb_stall, 0);
    // starvation: LU dst 9 loses four times, then forced
    lu_valid = 1; lu_dst = 9; lu_data = 32'h99;
    step("sv_acc");
    lu_valid = 0;
    wb_w = 1;
    for (int k = 0; k < 4; k++) begin
      wb_dst = 5'(10 + k); wb_data = 32'(k + 'h100);
      step("sv_a");
      chk("sv_dst", o_rf_dst, 10 + k);
      chk("sv_stall", o_wb_stall, (k == 3) ? 1 : 0);
    end
    wb_dst = 14; wb_data = 32'h104;
    step("sv_force");
    chk("sv_b_dst", o_rf_dst, 9); chk("sv_b_data", o_rf_data, 32'h99); chk("sv_stall_off", o_wb_stall, 0);
    step("sv_resume");
    chk("sv_resume_dst", o_rf_dst, 14); chk("sv_resume_w", o_rf_w, 1);
    // x0 handling
    idle_inputs();
    wb_w = 1; wb_dst = 0; wb_data = 32'hFFFF;
    lu_valid = 1; lu_dst = 0; lu_data = 32'hAAAA;
    iss_set = 1; iss_dst = 0;
    step("x0");
    chk("x0_w", o_rf_w, 0); chk("x0_busy0", o_busy[0], 0); chk("x0_rdy", o_lu_ready, 1);
    idle_inputs();
    step("x0_after");
    chk("x0_w2", o_rf_w, 0); chk("x0_rdy2", o_lu_ready, 1);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      wb_w = ($urandom_range(0, 3) != 0);
      wb_dst = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      lu_valid = ($urandom_range(0, 2) == 0);
      lu_dst = 5'($urandom_range(0, 7));
      lu_data = $urandom;
      iss_set = ($urandom_range(0, 3) == 0);
      iss_dst = 5'($urandom_range(0, 7));
      step("rnd");
    end
    // asynchronous reset with traffic present
    idle_inputs();
    lu_valid = 1; lu_dst = 8; lu_data = 32'h88;
    iss_set = 1; iss_dst = 4;
    wb_w = 1; wb_dst = 6; wb_data = 32'h66;
    step("pre_rst");
    #2;
    rst = 1;
    model_reset();
    #1;
    chk("rst_w", o_rf_w, 0); chk("rst_busy", o_busy, 0);
    chk("rst_rdy", o_lu_ready, 1); chk("rst_stall", o_wb_stall, 0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      check_all("rst_hold");
    end
    rst = 0;
    idle_inputs();
    step("post_rst");
    chk("post_rst_w", o_rf_w, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
